pulse_peak_detector: RTL and testbench
======================================

// Module: pulse_peak_detector
// PURPOSE
//  Consumer end of the shaping chain: takes one filter output stream (v1..v21 style), finds pulses
//  crossing a programmable threshold, and measures peak amplitude and peak timestamp.
//  Each pulse becomes one event, queued in a small FIFO and drained over a valid/ready interface.
//  Sits in the filter top level, after each filter, feeding the readout/histogram logic.
// PARAMETERS
//  DATA_W      16  width of input_data / threshold / out_amplitude (two's complement); top sets SIZE_FILTER_DATA
//  TS_W        24  width of free-running timestamp counter and out_time
//  HOLD_W       8  width of holdoff input
//  FIFO_DEPTH   4  event FIFO entries; power of 2, >=2
// PORTS
//  clk            in   1        single clock, all logic rising-edge
//  reset          in   1        synchronous, active-high
//  input_data     in   DATA_W   filter output sample, signed, one per clk
//  threshold      in   DATA_W   signed trigger level; sampled every clk
//  holdoff        in   HOLD_W   dead cycles after each pulse end
//  out_ready      in   1        downstream accepts event
//  out_valid      out  1        FIFO non-empty
//  out_amplitude  out  DATA_W   peak sample of head event
//  out_time       out  TS_W     timestamp of peak sample of head event
//  out_pileup     out  1        head event saw a second rise inside the pulse
//  drop_cnt       out  8        events lost to full FIFO, saturating at 255
// BEHAVIOUR
//  - Reset: all outputs 0, FIFO empty, ts=0, FSM=IDLE. Reset mid-pulse discards the pulse; no event.
//  - ts increments every clk, wraps 2^TS_W-1 -> 0; no flag at wrap.
//  - All compares signed. "above" = input_data > threshold (strict).
//  - FSM, one sample per clk:
//    IDLE: above -> RISE; peak<=input_data, ptime<=ts, pu<=0.
//    RISE: input_data > peak -> peak/ptime update. input_data < peak -> FALL. Equal: stay, keep first time.
//      not above -> END.
//    FALL: input_data > prev sample while above -> pu<=1, RISE (peak keeps tracking max).
//      not above -> END.
//    END (1 clk): push {peak,ptime,pu}; holdoff==0 -> IDLE else HOLDOFF, cnt<=holdoff-1.
//    HOLDOFF: cnt==0 -> IDLE else cnt-1. Input ignored (holdoff=N gives N dead cycles).
//  - Latency: sample going not-above at clk n -> END at n+1 -> out_valid high at n+2 if FIFO was empty.
//  - Handshake: pop on out_valid && out_ready. Head fields stable while out_valid && !out_ready.
//  - Full FIFO: push in same clk as pop is accepted. Push while full without pop -> event dropped,
//    drop_cnt+1 (saturating). Pop on empty: ignored.
//  - Pulse still above threshold: no timeout; event only on return below threshold.
//  - threshold change mid-pulse: takes effect on next sample compare.
// CONFIGURATION
//  PEAK_DET_PILEUP_REJECT_EN defined: events with pu=1 are not pushed and not counted in drop_cnt;
//    out_pileup tied 0. FSM timing unchanged (END and HOLDOFF still run).
//  Not defined: pile-up events pushed with out_pileup=1.
// TESTING
//  - thr=100, holdoff=0, samples 0,50,150,300,200,80,0, out_ready=1 -> 1 event amp=300,
//    time = ts of the 300 sample, pileup=0; out_valid 2 clk after the 80 sample.
//  - thr=100, samples 0,200,150,250,90 -> amp=250, pileup=1; with PEAK_DET_PILEUP_REJECT_EN: no event.
//  - out_ready=0, 6 pulses, FIFO_DEPTH=4 -> 4 events held in order, drop_cnt=2; release ready ->
//    4 pops, then out_valid=0.
//  - holdoff=5, 2nd pulse starts 3 clk after END -> ignored; 2nd pulse starting 6 clk after END -> detected.
//  - reset asserted 1 clk while in RISE at amp 400 -> no event; all outputs 0; ts restarts at 0.
//  - TS_W=4: peak at ts=15 then 2nd peak after wrap -> out_time 15 then a small value (wrap), no error.

Source files
------------

// File: rtl/pulse_peak_detector.sv
// pulse_peak_detector
//   Watches one signed filter output stream, detects pulses that rise strictly
//   above a programmable threshold, and records each pulse's peak amplitude,
//   the timestamp of that peak, and whether a second rise (pile-up) occurred
//   inside the pulse. Each finished pulse becomes one event in a small FIFO
//   that is drained over a valid/ready interface.
//
//   Build option: PEAK_DET_PILEUP_REJECT_EN
//     defined     -> pile-up events are silently discarded (not counted as
//                    drops) and out_pileup is tied low
//     not defined -> pile-up events are queued with out_pileup = 1
//
//   Ports
//     clk            rising-edge clock
//     reset          synchronous, active-high
//     input_data     signed sample, one per clock
//     threshold      signed trigger level, compared every clock
//     holdoff        number of dead cycles after each pulse end
//     out_ready      downstream accepts the head event
//     out_valid      FIFO holds at least one event
//     out_amplitude  peak sample of the head event
//     out_time       timestamp of the head event's peak sample
//     out_pileup     head event contained a second rise
//     drop_cnt       events lost to a full FIFO, saturates at 255
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | waiting for a sample above threshold
//   S_RISE   | inside a pulse, tracking the running maximum
//   S_FALL   | inside a pulse, past the peak; a new rise marks pile-up
//   S_END    | one cycle: push the finished event, load holdoff counter
//   S_HOLDOFF| dead time, input ignored until the counter expires
module pulse_peak_detector #(
    parameter int DATA_W     = 16,
    parameter int TS_W       = 24,
    parameter int HOLD_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] input_data,
    input  logic [DATA_W-1:0] threshold,
    input  logic [HOLD_W-1:0] holdoff,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_amplitude,
    output logic [TS_W-1:0]   out_time,
    output logic              out_pileup,
    output logic [7:0]        drop_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RISE    = 3'd1,
        S_FALL    = 3'd2,
        S_END     = 3'd3,
        S_HOLDOFF = 3'd4
    } state_t;

    state_t state, state_next;

    logic [TS_W-1:0]   ts;
    logic [DATA_W-1:0] peak;
    logic [DATA_W-1:0] prev_data;
    logic [TS_W-1:0]   ptime;
    logic              pu;
    logic [HOLD_W-1:0] cnt;

    logic above;
    logic above_peak;
    logic below_peak;
    logic above_prev;

    always_comb begin
        above      = $signed(input_data) > $signed(threshold);
        above_peak = $signed(input_data) > $signed(peak);
        below_peak = $signed(input_data) < $signed(peak);
        above_prev = $signed(input_data) > $signed(prev_data);
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (above) state_next = S_RISE;
            S_RISE: begin
                if (!above)          state_next = S_END;
                else if (below_peak) state_next = S_FALL;
            end
            S_FALL: begin
                if (!above)          state_next = S_END;
                else if (above_prev) state_next = S_RISE;
            end
            S_END:     state_next = (holdoff == '0) ? S_IDLE : S_HOLDOFF;
            S_HOLDOFF: if (cnt == '0) state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    logic push_req;

    always_comb begin
        push_req = 1'b0;
        if (state == S_END) begin
`ifdef PEAK_DET_PILEUP_REJECT_EN
            push_req = !pu;
`else
            push_req = 1'b1;
`endif
        end
    end

    // ---------------- timestamp and pulse measurement ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            ts        <= '0;
            peak      <= '0;
            ptime     <= '0;
            pu        <= 1'b0;
            prev_data <= '0;
            cnt       <= '0;
        end else begin
            ts        <= ts + TS_W'(1);
            prev_data <= input_data;
            case (state)
                S_IDLE: begin
                    if (above) begin
                        peak  <= input_data;
                        ptime <= ts;
                        pu    <= 1'b0;
                    end
                end
                S_RISE, S_FALL: begin
                    // Strict '>' keeps the first timestamp of a flat top.
                    if (above && above_peak) begin
                        peak  <= input_data;
                        ptime <= ts;
                    end
                    if (state == S_FALL && above && above_prev) pu <= 1'b1;
                end
                S_END:     cnt <= holdoff - HOLD_W'(1);
                S_HOLDOFF: if (cnt != '0) cnt <= cnt - HOLD_W'(1);
                default: ;
            endcase
        end
    end

    // ---------------- event FIFO ----------------
    logic [DATA_W-1:0] mem_amp  [FIFO_DEPTH];
    logic [TS_W-1:0]   mem_time [FIFO_DEPTH];
`ifndef PEAK_DET_PILEUP_REJECT_EN
    logic              mem_pu   [FIFO_DEPTH];
`endif
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          pop, push_ok;

    // A pop in the same cycle frees the slot the push needs.
    always_comb begin
        pop     = out_valid && out_ready;
        push_ok = push_req && ((count < DEPTH) || pop);
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_amp[wr_ptr]  <= peak;
            mem_time[wr_ptr] <= ptime;
`ifndef PEAK_DET_PILEUP_REJECT_EN
            mem_pu[wr_ptr]   <= pu;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_cnt <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (push_req && !push_ok && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;
        end
    end

    // Head fields are forced to zero while empty so reset leaves all outputs 0.
    always_comb begin
        out_valid     = (count != '0);
        out_amplitude = out_valid ? mem_amp[rd_ptr]  : '0;
        out_time      = out_valid ? mem_time[rd_ptr] : '0;
`ifdef PEAK_DET_PILEUP_REJECT_EN
        out_pileup    = 1'b0;
`else
        out_pileup    = out_valid ? mem_pu[rd_ptr] : 1'b0;
`endif
    end

endmodule

// File: tb/tb_pulse_peak_detector.sv
// tb_pulse_peak_detector
//   Self-checking bench for pulse_peak_detector: single-pulse vector table,
//   hand sequences (FIFO full, holdoff, reset mid-pulse, timestamp wrap on a
//   TS_W=4 instance, drop counter saturation) and randomized streams checked
//   against an event-level reference model.
module tb_pulse_peak_detector;
    localparam int D = 4;

`ifdef PEAK_DET_PILEUP_REJECT_EN
    localparam bit REJ = 1'b1;
`else
    localparam bit REJ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] input_data;
    logic [15:0] threshold;
    logic [7:0]  holdoff;
    logic        out_ready;
    logic        out_valid;
    logic [15:0] out_amplitude;
    logic [23:0] out_time;
    logic        out_pileup;
    logic [7:0]  drop_cnt;

    logic        v4;
    logic [15:0] amp4;
    logic [3:0]  time4;
    logic        pu4;
    logic [7:0]  drop4;

    pulse_peak_detector #(.DATA_W(16), .TS_W(24), .HOLD_W(8), .FIFO_DEPTH(D)) dut (
        .clk(clk), .reset(reset), .input_data(input_data), .threshold(threshold),
        .holdoff(holdoff), .out_ready(out_ready), .out_valid(out_valid),
        .out_amplitude(out_amplitude), .out_time(out_time), .out_pileup(out_pileup),
        .drop_cnt(drop_cnt)
    );

    pulse_peak_detector #(.DATA_W(16), .TS_W(4), .HOLD_W(8), .FIFO_DEPTH(D)) dut4 (
        .clk(clk), .reset(reset), .input_data(input_data), .threshold(threshold),
        .holdoff(holdoff), .out_ready(out_ready), .out_valid(v4),
        .out_amplitude(amp4), .out_time(time4), .out_pileup(pu4),
        .drop_cnt(drop4)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the reset edge.
    task automatic do_reset();
        reset      = 1'b1;
        input_data = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Drive one sample for the next rising edge, return at the following negedge.
    task automatic step(input int data);
        input_data = 16'(data);
        @(negedge clk);
    endtask

    // ---------------- event-level reference model ----------------
    typedef struct {
        int push_idx;
        int amp;
        int tim;
        bit pu;
    } ev_t;

    int stim_q[$];
    bit rdy_q[$];

    task automatic run_model(input int thr, input int hold, input string tag, output int pops);
        ev_t evq[$];
        ev_t mq[$];
        ev_t ev;
        int  n, i, j, peak, pt, k0, mdrop;
        bit  pu;
        n = stim_q.size();
        i = 0;
        // A pulse is a maximal run of samples above thr. Pile-up: after the
        // first sample that falls below the running peak, any later sample
        // larger than its predecessor.
        while (i < n) begin
            if (stim_q[i] > thr) begin
                peak = stim_q[i]; pt = i; k0 = -1; pu = 1'b0; j = i + 1;
                while (j < n && stim_q[j] > thr) begin
                    if (k0 < 0 && stim_q[j] < peak) k0 = j;
                    else if (k0 >= 0 && stim_q[j] > stim_q[j-1]) pu = 1'b1;
                    if (stim_q[j] > peak) begin peak = stim_q[j]; pt = j; end
                    j++;
                end
                if (j >= n) break;
                if (!(REJ && pu)) begin
                    ev.push_idx = j + 1; ev.amp = peak; ev.tim = pt; ev.pu = pu;
                    evq.push_back(ev);
                end
                // End cycle, then hold dead cycles, then idle again.
                i = j + 2 + hold;
            end else begin
                i++;
            end
        end

        threshold = 16'(thr);
        holdoff   = 8'(hold);
        out_ready = 1'b0;
        do_reset();
        mdrop = 0;
        pops  = 0;
        for (int c = 0; c < n; c++) begin
            input_data = 16'(stim_q[c]);
            out_ready  = rdy_q[c];
            if (out_valid && out_ready) pops++;
            @(negedge clk);
            if (mq.size() > 0 && rdy_q[c]) void'(mq.pop_front());
            if (evq.size() > 0 && evq[0].push_idx == c) begin
                if (mq.size() < D) mq.push_back(evq[0]);
                else if (mdrop < 255) mdrop++;
                void'(evq.pop_front());
            end
            check({tag, "_valid"}, int'(out_valid), int'(mq.size() > 0));
            check({tag, "_drop"}, int'(drop_cnt), mdrop);
            if (mq.size() > 0) begin
                check({tag, "_amp"}, int'($signed(out_amplitude)), mq[0].amp);
                check({tag, "_time"}, int'(out_time), mq[0].tim);
                check({tag, "_pileup"}, int'(out_pileup), int'(mq[0].pu));
            end
        end
        out_ready = 1'b0;
    endtask

    // ---------------- single-pulse vector table ----------------
    typedef struct {
        int thr;
        int smp[8];
        int amp;
        int tim;
        int pu;
        int vat;   // step index after which out_valid first rises, -1 = never
    } vec_t;

    vec_t tbl_q[$];

    task automatic add_vec(input int thr, input int a0, input int a1, input int a2, input int a3,
                           input int a4, input int a5, input int a6, input int a7,
                           input int amp, input int tim, input int pu, input int vat);
        vec_t v;
        v.thr = thr;
        v.smp[0] = a0; v.smp[1] = a1; v.smp[2] = a2; v.smp[3] = a3;
        v.smp[4] = a4; v.smp[5] = a5; v.smp[6] = a6; v.smp[7] = a7;
        v.amp = amp; v.tim = tim; v.pu = pu; v.vat = vat;
        tbl_q.push_back(v);
    endtask

    initial begin
        int pops, first, g_amp, g_tim, g_pu, p, thr, hold, burst, val;
        vec_t v;

        add_vec(100, 0, 50, 150, 300, 200, 80, 0, 0,  300, 3, 0, 6);
        add_vec(100, 0, 200, 150, 250, 90, 0, 0, 0,   250, 3, 1, REJ ? -1 : 5);
        add_vec(10,  0, 50, 50, 50, 20, 5, 0, 0,      50, 1, 0, 6);
        add_vec(-100, -200, -50, -80, -150, -200, -200, -200, -200, -50, 1, 0, 4);
        add_vec(100, 0, 100, 100, 101, 100, 0, 0, 0,  101, 3, 0, 5);
        add_vec(100, 0, 100, 99, 50, 0, 0, 0, 0,      0, 0, 0, -1);
        add_vec(0,   0, 0, 5, 0, 0, 0, 0, 0,          5, 2, 0, 4);
        add_vec(100, 0, 200, 200, 200, 200, 200, 200, 200, 0, 0, 0, -1);

        reset      = 1'b1;
        input_data = '0;
        threshold  = 16'd100;
        holdoff    = '0;
        out_ready  = 1'b0;
        @(negedge clk);

        // Reset state
        do_reset();
        check("rst_valid", int'(out_valid), 0);
        check("rst_amp", int'(out_amplitude), 0);
        check("rst_time", int'(out_time), 0);
        check("rst_pileup", int'(out_pileup), 0);
        check("rst_drop", int'(drop_cnt), 0);

        // Table
        for (int t = 0; t < tbl_q.size(); t++) begin
            v = tbl_q[t];
            threshold = 16'(v.thr);
            holdoff   = '0;
            out_ready = 1'b0;
            do_reset();
            first = -1; g_amp = 0; g_tim = 0; g_pu = 0;
            for (int k = 0; k < 12; k++) begin
                step((k < 8) ? v.smp[k] : v.smp[7]);
                if (out_valid && first < 0) begin
                    first = k;
                    g_amp = int'($signed(out_amplitude));
                    g_tim = int'(out_time);
                    g_pu  = int'(out_pileup);
                end
            end
            check($sformatf("tbl%0d_valid_at", t), first, v.vat);
            if (v.vat >= 0) begin
                check($sformatf("tbl%0d_amp", t), g_amp, v.amp);
                check($sformatf("tbl%0d_time", t), g_tim, v.tim);
                check($sformatf("tbl%0d_pileup", t), g_pu, v.pu);
            end
        end

        // FIFO full: six pulses with ready low, then drain
        stim_q.delete(); rdy_q.delete();
        for (int q = 0; q < 6; q++) begin
            stim_q.push_back(0); stim_q.push_back(200 + 10 * q);
            stim_q.push_back(0); stim_q.push_back(0);
        end
        for (int q = 0; q < 16; q++) stim_q.push_back(0);
        for (int c = 0; c < stim_q.size(); c++) rdy_q.push_back(c >= 28);
        run_model(100, 0, "full", pops);
        check("full_pops", pops, 4);
        check("full_drop_final", int'(drop_cnt), 2);
        check("full_valid_final", int'(out_valid), 0);

        // Holdoff=5: pulse 3 clk after END ignored, pulse 6 clk after END detected
        stim_q.delete(); rdy_q.delete();
        for (int c = 0; c < 20; c++) begin
            stim_q.push_back((c == 1) ? 200 : (c == 6) ? 300 : (c == 9) ? 400 : 0);
            rdy_q.push_back(1'b1);
        end
        run_model(100, 5, "hold", pops);
        check("hold_pops", pops, 2);

        // Reset for one clock while in RISE at 400
        threshold = 16'd100; holdoff = '0; out_ready = 1'b0;
        do_reset();
        step(0); step(400); step(400);
        reset = 1'b1;
        step(400);
        reset = 1'b0;
        check("midrst_valid", int'(out_valid), 0);
        check("midrst_amp", int'(out_amplitude), 0);
        check("midrst_time", int'(out_time), 0);
        check("midrst_pileup", int'(out_pileup), 0);
        check("midrst_drop", int'(drop_cnt), 0);
        first = -1;
        for (int k = 0; k < 8; k++) begin
            step((k == 5) ? 250 : 0);
            if (out_valid && first < 0) begin
                first = k;
                g_amp = int'($signed(out_amplitude));
                g_tim = int'(out_time);
            end
        end
        check("midrst_valid_at", first, 7);
        check("midrst_next_amp", g_amp, 250);
        check("midrst_next_time", g_tim, 5);

        // Timestamp wrap on the TS_W=4 instance
        threshold = 16'd100; holdoff = '0; out_ready = 1'b0;
        do_reset();
        for (int k = 0; k < 24; k++) step((k == 15) ? 200 : (k == 20) ? 300 : 0);
        check("wrap_valid1", int'(v4), 1);
        check("wrap_time1", int'(time4), 15);
        check("wrap_amp1", int'($signed(amp4)), 200);
        check("wide_time1", int'(out_time), 15);
        out_ready = 1'b1;
        step(0);
        out_ready = 1'b0;
        check("wrap_valid2", int'(v4), 1);
        check("wrap_time2", int'(time4), 4);
        check("wrap_amp2", int'($signed(amp4)), 300);
        check("wide_time2", int'(out_time), 20);
        out_ready = 1'b1;
        step(0);
        out_ready = 1'b0;
        check("wrap_empty", int'(v4), 0);

        // Drop counter saturation: 263 pulses, ready low
        stim_q.delete(); rdy_q.delete();
        for (int q = 0; q < 263; q++) begin
            stim_q.push_back(200); stim_q.push_back(0); stim_q.push_back(0);
        end
        for (int q = 0; q < 4; q++) stim_q.push_back(0);
        for (int c = 0; c < stim_q.size(); c++) rdy_q.push_back(1'b0);
        run_model(100, 0, "sat", pops);
        check("sat_drop", int'(drop_cnt), 255);
        check("sat_pops", pops, 0);

        // Randomized streams
        for (int r = 0; r < 4; r++) begin
            stim_q.delete(); rdy_q.delete();
            thr   = int'($urandom_range(0, 150));
            hold  = int'($urandom_range(0, 4));
            burst = 0;
            for (int c = 0; c < 400; c++) begin
                if (burst == 0 && $urandom_range(0, 5) == 0) burst = int'($urandom_range(1, 8));
                if (c >= 388) val = -100;
                else if (burst > 0) begin
                    val = thr - 30 + int'($urandom_range(0, 330));
                    burst--;
                end else val = -100 + int'($urandom_range(0, 100 + thr));
                stim_q.push_back(val);
                rdy_q.push_back($urandom_range(0, 99) < (20 + 25 * r));
            end
            run_model(thr, hold, $sformatf("rnd%0d", r), pops);
        end

        p = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
